mmu_acc: RTL and testbench
==========================

# mmu_acc

Parametrised, double-buffered matrix multiply unit for the TPU datapath. Computes acc_out = W × D for SIZE×SIZE operands, one output row per cycle, with a weight FIFO of configurable depth, selectable signed/unsigned arithmetic, and an accumulate mode that adds into held results for K-tiled products. It sits between the weight/data fetch logic and the output writeback stage, and extends the fixed 8-bit, unsigned, overwrite-only MMU.

## Interface
- SIZE, 2: matrix dimension; must be ≥ 1.
- DATA_W, 8: width of each weight/data element.
- ACC_W, 32: width of each accumulator element; must be ≥ 2·DATA_W.
- WFIFO_DEPTH, 2: weight FIFO entries; must be ≥ 1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- w_push  in  1  push w_in into the weight FIFO.
- w_in  in  [SIZE][SIZE]×DATA_W  weight matrix, w_in[i][k].
- w_rdy  out  1  FIFO not full.
- w_ld_start  in  1  pop FIFO head into the shadow weight buffer.
- w_ld_rdy  out  1  FIFO not empty.
- w_swap  in  1  copy shadow weights to active weights.
- data_push  in  1  load data_in into the data register.
- data_in  in  [SIZE][SIZE]×DATA_W  data matrix, d[k][j].
- data_rdy  out  1  data register empty.
- signed_mode  in  1  sampled on run accept; 1 = two's-complement operands.
- accumulate  in  1  sampled on run accept; 1 = add into current acc_out.
- mult_run  in  1  start a multiply.
- mult_rdy  out  1  idle, active weights valid, data valid, and acc_out_rdy low.
- busy  out  1  FSM in COMPUTE.
- acc_out_rdy  out  1  result held and unread.
- acc_out_pop  in  1  acknowledge result.
- acc_out  out  [SIZE][SIZE]×ACC_W  result matrix.

## Operation
- FSM states: IDLE, COMPUTE, DONE. IDLE→COMPUTE on mult_run && mult_rdy. COMPUTE lasts exactly SIZE cycles (row counter r = 0..SIZE-1), then goes to DONE. DONE→IDLE on acc_out_pop.
- Arithmetic: acc_out[r][j] = base + Σk w_act[r][k]·d[k][j], where base = acc_out[r][j] if accumulate was latched, else 0. Products are 2·DATA_W wide, sign-extended (signed_mode=1) or zero-extended to ACC_W. The sum wraps modulo 2^ACC_W. No saturation.
- Weight FIFO:
  - Push is accepted only when w_rdy. Push while full is ignored.
  - w_ld_start with w_ld_rdy pops the head into shadow and sets shadow_valid. It overwrites an unswapped shadow.
  - Simultaneous push and pop are both honoured when legal. A pop on an empty FIFO is ignored, even if a push occurs in the same cycle.
- Swap: w_swap copies shadow→active, sets active_valid, and clears shadow_valid.
  - Honoured only in IDLE or DONE with shadow_valid set.
  - Ignored in COMPUTE, and ignored in the cycle a run is accepted.
  - Swap and load in the same cycle: swap takes the old shadow, the load writes the new one, and shadow_valid stays 1.
- Data register: data_push is accepted only when data_rdy; otherwise ignored. Data is consumed (data_rdy rises) on the last COMPUTE cycle.
- Active weights persist across runs until the next swap.
- acc_out holds its value after pop and is the base for a following accumulate run.

## Timing
- Reset values: acc_out all 0; acc_out_rdy, mult_rdy, busy, w_ld_rdy = 0; w_rdy, data_rdy = 1. FIFO is empty and shadow_valid = active_valid = 0. The FSM is in IDLE.
- Reset mid-operation aborts COMPUTE and clears all state to the reset values above.
- Run accepted in cycle T:
  - busy is high in cycles T+1..T+SIZE.
  - Row r of acc_out updates at the end of cycle T+1+r.
  - data_rdy is 1 and acc_out_rdy is 1 from cycle T+SIZE+1.
  - Latency from run to result is SIZE+1 cycles.
- Pop accepted in cycle P (acc_out_rdy high): acc_out_rdy is 0 at P+1 and mult_rdy may rise at P+1. A pop while acc_out_rdy is low is ignored.
- Status outputs are combinational from registered state.
- A push or load in cycle T is visible in the status outputs at T+1.

## Test plan
- Basic run (SIZE=2), W=[[1,2],[3,4]], D=[[5,6],[7,8]], unsigned: push, load, swap, push data, run → acc_out_rdy exactly 3 cycles after run; acc_out=[[0x13,0x16],[0x2B,0x32]].
- Accumulate: after the basic run, pop, push the same D, run with accumulate=1 → [[0x26,0x2C],[0x56,0x64]].
- Signed vs unsigned, W=[[0xFF,0],[0,0xFF]], D=[[2,3],[4,5]]:
  - signed_mode=1 → [[0xFFFFFFFE,0xFFFFFFFD],[0xFFFFFFFC,0xFFFFFFFB]].
  - signed_mode=0 → [[0x1FE,0x2FD],[0x3FC,0x4FB]].
- FIFO boundaries, WFIFO_DEPTH=2:
  - Three pushes → w_rdy low after the second; the third is dropped.
  - Two loads yield the first two matrices in order; w_ld_rdy is then low.
  - A load while empty leaves the shadow unchanged.
- Double buffering: during COMPUTE with W1, load W2 and assert w_swap → swap ignored and the result uses W1. After pop, swap, and a rerun → the result uses W2.
- Reset: assert rst in the second COMPUTE cycle → all outputs return to reset values immediately; mult_rdy stays low until new weights are loaded and swapped.

Source files
------------

// File: rtl/mmu_acc.sv
// Double-buffered SIZE x SIZE matrix multiply with a weight FIFO, signed/unsigned
// arithmetic and an accumulate mode; one output row is produced per COMPUTE cycle.
module mmu_acc #(
  parameter int SIZE        = 2,
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 32,
  parameter int WFIFO_DEPTH = 2
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_w_push,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0]   i_w_in,
  output logic                                    o_w_rdy,
  input  logic                                    i_w_ld_start,
  output logic                                    o_w_ld_rdy,
  input  logic                                    i_w_swap,
  input  logic                                    i_data_push,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0]   i_data_in,
  output logic                                    o_data_rdy,
  input  logic                                    i_signed_mode,
  input  logic                                    i_accumulate,
  input  logic                                    i_mult_run,
  output logic                                    o_mult_rdy,
  output logic                                    o_busy,
  output logic                                    o_acc_out_rdy,
  input  logic                                    i_acc_out_pop,
  output logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0]    o_acc_out
);

  localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int PW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int CW = $clog2(WFIFO_DEPTH + 1);

  typedef logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] mat_t;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [RW-1:0]                  r_row;
  logic                           r_sgn;
  logic                           r_acc_mode;
  mat_t                           r_fifo [WFIFO_DEPTH];
  logic [PW-1:0]                  r_wr;
  logic [PW-1:0]                  r_rd;
  logic [CW-1:0]                  r_cnt;
  mat_t                           r_shadow;
  mat_t                           r_w_act;
  logic                           r_shadow_valid;
  logic                           r_active_valid;
  mat_t                           r_data;
  logic                           r_data_valid;
  logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0] r_acc;
  logic [SIZE-1:0][ACC_W-1:0]     w_row_res;

  logic w_run_acc;
  logic w_last_row;
  logic w_push_ok;
  logic w_pop_ok;
  logic w_swap_ok;
  logic w_consume;

  // Product widened to 2*DATA_W, then sign- or zero-extended into the accumulator width
  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic              sgn);
    logic [2*DATA_W-1:0] a_x;
    logic [2*DATA_W-1:0] b_x;
    logic [2*DATA_W-1:0] p;
    logic [ACC_W-1:0]    res;
    if (sgn) begin
      a_x = {{DATA_W{a[DATA_W-1]}}, a};
      b_x = {{DATA_W{b[DATA_W-1]}}, b};
    end else begin
      a_x = {{DATA_W{1'b0}}, a};
      b_x = {{DATA_W{1'b0}}, b};
    end
    p = a_x * b_x;
    if (sgn) begin
      res = ACC_W'($signed(p));
    end else begin
      res = ACC_W'(p);
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(WFIFO_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign o_w_rdy       = (r_cnt != CW'(WFIFO_DEPTH));
  assign o_w_ld_rdy    = (r_cnt != {CW{1'b0}});
  assign o_data_rdy    = ~r_data_valid;
  assign o_busy        = (r_state == ST_COMPUTE);
  assign o_acc_out_rdy = (r_state == ST_DONE);
  assign o_mult_rdy    = (r_state == ST_IDLE) & r_active_valid & r_data_valid & ~o_acc_out_rdy;
  assign o_acc_out     = r_acc;

  assign w_run_acc  = i_mult_run & o_mult_rdy;
  assign w_last_row = (r_row == RW'(SIZE - 1));
  assign w_push_ok  = i_w_push & o_w_rdy;
  assign w_pop_ok   = i_w_ld_start & o_w_ld_rdy;
  assign w_consume  = o_busy & w_last_row;
  // A swap never lands mid-compute nor on the run-accept edge, so a run always sees stable weights
  assign w_swap_ok  = i_w_swap & r_shadow_valid & ~w_run_acc &
                      ((r_state == ST_IDLE) | (r_state == ST_DONE));

  // Next-state logic for the run sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_run_acc) w_state_nxt = ST_COMPUTE;
        else           w_state_nxt = ST_IDLE;
      end
      ST_COMPUTE: begin
        if (w_last_row) w_state_nxt = ST_DONE;
        else            w_state_nxt = ST_COMPUTE;
      end
      ST_DONE: begin
        if (i_acc_out_pop) w_state_nxt = ST_IDLE;
        else               w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result row for the current row counter, optionally added onto the held result
  always_comb begin
    w_row_res = {(SIZE*ACC_W){1'b0}};
    for (int j = 0; j < SIZE; j++) begin
      w_row_res[j] = r_acc_mode ? r_acc[r_row][j] : {ACC_W{1'b0}};
      for (int k = 0; k < SIZE; k++) begin
        w_row_res[j] = w_row_res[j] + mul_ext(r_w_act[r_row][k], r_data[k][j], r_sgn);
      end
    end
  end

  // State register, row counter and per-run mode latches
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_row      <= {RW{1'b0}};
      r_sgn      <= 1'b0;
      r_acc_mode <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_run_acc) begin
        r_row      <= {RW{1'b0}};
        r_sgn      <= i_signed_mode;
        r_acc_mode <= i_accumulate;
      end else if (o_busy && !w_last_row) begin
        r_row <= r_row + RW'(1);
      end
    end
  end

  // Weight FIFO storage, pointers and occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr  <= {PW{1'b0}};
      r_rd  <= {PW{1'b0}};
      r_cnt <= {CW{1'b0}};
      for (int i = 0; i < WFIFO_DEPTH; i++) r_fifo[i] <= {(SIZE*SIZE*DATA_W){1'b0}};
    end else begin
      if (w_push_ok) begin
        r_fifo[r_wr] <= i_w_in;
        r_wr         <= ptr_inc(r_wr);
      end
      if (w_pop_ok) r_rd <= ptr_inc(r_rd);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Shadow/active weight buffers; a same-cycle swap takes the old shadow
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow       <= {(SIZE*SIZE*DATA_W){1'b0}};
      r_w_act        <= {(SIZE*SIZE*DATA_W){1'b0}};
      r_shadow_valid <= 1'b0;
      r_active_valid <= 1'b0;
    end else begin
      if (w_swap_ok) begin
        r_w_act        <= r_shadow;
        r_active_valid <= 1'b1;
      end
      if (w_pop_ok) begin
        r_shadow       <= r_fifo[r_rd];
        r_shadow_valid <= 1'b1;
      end else if (w_swap_ok) begin
        r_shadow_valid <= 1'b0;
      end
    end
  end

  // Data operand register, released on the final compute row
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data       <= {(SIZE*SIZE*DATA_W){1'b0}};
      r_data_valid <= 1'b0;
    end else if (w_consume) begin
      r_data_valid <= 1'b0;
    end else if (i_data_push && !r_data_valid) begin
      r_data       <= i_data_in;
      r_data_valid <= 1'b1;
    end
  end

  // Result matrix, one row written per compute cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= {(SIZE*SIZE*ACC_W){1'b0}};
    end else if (o_busy) begin
      r_acc[r_row] <= w_row_res;
    end
  end

endmodule

// File: tb/tb_mmu_acc.sv
// Directed bench for mmu_acc (SIZE=2, DATA_W=8, ACC_W=32, WFIFO_DEPTH=2)
// with hand-computed expected matrices.
module tb_mmu_acc;

  typedef logic [1:0][1:0][7:0]  mat_t;
  typedef logic [1:0][1:0][31:0] accm_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  w_push = 1'b0, w_ld_start = 1'b0, w_swap = 1'b0, data_push = 1'b0;
  logic  signed_mode = 1'b0, accumulate = 1'b0, mult_run = 1'b0, acc_out_pop = 1'b0;
  mat_t  w_in = '0, data_in = '0;
  logic  w_rdy, w_ld_rdy, data_rdy, mult_rdy, busy, acc_out_rdy;
  accm_t acc_out;

  int n_checks = 0;
  int n_fail   = 0;

  mmu_acc #(.SIZE(2), .DATA_W(8), .ACC_W(32), .WFIFO_DEPTH(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_w_push(w_push), .i_w_in(w_in), .o_w_rdy(w_rdy),
    .i_w_ld_start(w_ld_start), .o_w_ld_rdy(w_ld_rdy), .i_w_swap(w_swap),
    .i_data_push(data_push), .i_data_in(data_in), .o_data_rdy(data_rdy),
    .i_signed_mode(signed_mode), .i_accumulate(accumulate),
    .i_mult_run(mult_run), .o_mult_rdy(mult_rdy), .o_busy(busy),
    .o_acc_out_rdy(acc_out_rdy), .i_acc_out_pop(acc_out_pop), .o_acc_out(acc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic mat_t mk(input logic [7:0] a00, a01, a10, a11);
    mat_t m;
    m[0][0] = a00; m[0][1] = a01; m[1][0] = a10; m[1][1] = a11;
    return m;
  endfunction

  function automatic accm_t mka(input logic [31:0] a00, a01, a10, a11);
    accm_t m;
    m[0][0] = a00; m[0][1] = a01; m[1][0] = a10; m[1][1] = a11;
    return m;
  endfunction

  // {w_rdy, w_ld_rdy, data_rdy, mult_rdy, busy, acc_out_rdy}
  function automatic logic [5:0] st();
    return {w_rdy, w_ld_rdy, data_rdy, mult_rdy, busy, acc_out_rdy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(input mat_t m);
    w_in = m; w_push = 1'b1; tick(); w_push = 1'b0;
  endtask

  task automatic load_w();
    w_ld_start = 1'b1; tick(); w_ld_start = 1'b0;
  endtask

  task automatic swap_w();
    w_swap = 1'b1; tick(); w_swap = 1'b0;
  endtask

  task automatic push_d(input mat_t m);
    data_in = m; data_push = 1'b1; tick(); data_push = 1'b0;
  endtask

  task automatic pop_res();
    acc_out_pop = 1'b1; tick(); acc_out_pop = 1'b0;
    chk("pop_rdy_low", acc_out_rdy, 1'b0);
  endtask

  // Run; optionally assert load+swap in the first compute cycle. Checks latency and result.
  task automatic do_run(input string tag, input logic sgn, input logic acc,
                        input logic mid_ld_swap, input accm_t exp);
    int lat;
    chk({tag, "_mult_rdy"}, mult_rdy, 1'b1);
    signed_mode = sgn; accumulate = acc; mult_run = 1'b1;
    tick();
    mult_run = 1'b0;
    lat = 1;
    chk({tag, "_busy"}, busy, 1'b1);
    if (mid_ld_swap) begin
      w_ld_start = 1'b1; w_swap = 1'b1;
      tick();
      w_ld_start = 1'b0; w_swap = 1'b0;
      lat++;
    end
    while (!acc_out_rdy && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_res"}, acc_out, exp);
    chk({tag, "_data_rdy"}, data_rdy, 1'b1);
  endtask

  mat_t w1, d1, ws, ds, ident, fa, fb, fc, fx;

  initial begin
    w1    = mk(8'd1, 8'd2, 8'd3, 8'd4);
    d1    = mk(8'd5, 8'd6, 8'd7, 8'd8);
    ws    = mk(8'hFF, 8'h00, 8'h00, 8'hFF);
    ds    = mk(8'd2, 8'd3, 8'd4, 8'd5);
    ident = mk(8'd1, 8'd0, 8'd0, 8'd1);
    fa    = mk(8'h11, 8'h12, 8'h13, 8'h14);
    fb    = mk(8'h21, 8'h22, 8'h23, 8'h24);
    fc    = mk(8'h31, 8'h32, 8'h33, 8'h34);
    fx    = mk(8'h41, 8'h42, 8'h43, 8'h44);

    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_status", st(), 6'b101000);
    chk("reset_acc", acc_out, '0);

    // Basic unsigned run
    push_w(w1);
    chk("push_ld_rdy", w_ld_rdy, 1'b1);
    load_w();
    chk("load_empty", w_ld_rdy, 1'b0);
    chk("no_act_mult_rdy", mult_rdy, 1'b0);
    swap_w();
    push_d(d1);
    do_run("basic", 1'b0, 1'b0, 1'b0, mka(32'h13, 32'h16, 32'h2B, 32'h32));

    // Accumulate onto held result
    pop_res();
    chk("after_pop_no_data", mult_rdy, 1'b0);
    push_d(d1);
    do_run("accum", 1'b0, 1'b1, 1'b0, mka(32'h26, 32'h2C, 32'h56, 32'h64));

    // Signed vs unsigned
    pop_res();
    push_w(ws); load_w(); swap_w();
    push_d(ds);
    do_run("signed", 1'b1, 1'b0, 1'b0,
           mka(32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFFFFFFFB));
    pop_res();
    push_d(ds);
    do_run("unsigned", 1'b0, 1'b0, 1'b0, mka(32'h1FE, 32'h2FD, 32'h3FC, 32'h4FB));

    // FIFO boundaries: third push dropped, order kept, empty load ignored
    pop_res();
    push_w(fa);
    chk("fifo_w_rdy_1", w_rdy, 1'b1);
    push_w(fb);
    chk("fifo_w_rdy_2", w_rdy, 1'b0);
    push_w(fc);
    chk("fifo_w_rdy_3", w_rdy, 1'b0);
    load_w();
    chk("fifo_ld_rdy_1", w_ld_rdy, 1'b1);
    chk("fifo_w_rdy_after_pop", w_rdy, 1'b1);
    swap_w();
    push_d(ident);
    do_run("fifo_first", 1'b0, 1'b0, 1'b0, mka(32'h11, 32'h12, 32'h13, 32'h14));
    pop_res();
    load_w();
    chk("fifo_ld_rdy_2", w_ld_rdy, 1'b0);
    load_w();
    swap_w();
    push_d(ident);
    do_run("fifo_second", 1'b0, 1'b0, 1'b0, mka(32'h21, 32'h22, 32'h23, 32'h24));

    // Double buffering: swap during compute is ignored
    pop_res();
    push_w(fx);
    push_d(ident);
    do_run("dbuf_w1", 1'b0, 1'b0, 1'b1, mka(32'h21, 32'h22, 32'h23, 32'h24));
    pop_res();
    swap_w();
    push_d(ident);
    do_run("dbuf_w2", 1'b0, 1'b0, 1'b0, mka(32'h41, 32'h42, 32'h43, 32'h44));

    // Reset in the second compute cycle
    pop_res();
    push_d(ident);
    chk("rst_pre_mult_rdy", mult_rdy, 1'b1);
    mult_run = 1'b1; tick(); mult_run = 1'b0;
    tick();
    chk("rst_pre_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_status", st(), 6'b101000);
    chk("rst_mid_acc", acc_out, '0);
    tick();
    rst = 1'b0;
    push_d(ident);
    chk("rst_no_weights", mult_rdy, 1'b0);
    push_w(fa); load_w();
    chk("rst_no_swap", mult_rdy, 1'b0);
    swap_w();
    chk("rst_rearmed", mult_rdy, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
